// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one registered ALU (alu_reg, 1-cycle latency)
// between two requesters, with one operation in flight and valid/ready on both sides.
module alu_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_cont,
  input  logic [WIDTH-1:0] alu_result,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_id
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       cont_q, cont_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             gnt0, gnt1;

  // prio_q == 0 means requester 0 wins a tie; a lone requester always wins.
  always_comb begin
    gnt0 = req0_valid && (!req1_valid || !prio_q);
    gnt1 = req1_valid && (!req0_valid ||  prio_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req0_valid || req1_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_CAPT;
      ST_CAPT: state_d = ST_RESP;
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready is masked during reset so a requester never sees an accept that is dropped.
  always_comb begin
    req0_ready = (state_q == ST_IDLE) && !reset && gnt0;
    req1_ready = (state_q == ST_IDLE) && !reset && gnt1;
  end

  always_comb begin
    prio_d  = prio_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    cont_d  = cont_q;
    data_d  = data_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt0 || gnt1) begin
          id_d   = gnt1;
          prio_d = gnt0;
          a_d    = gnt1 ? req1_a  : req0_a;
          b_d    = gnt1 ? req1_b  : req0_b;
          cont_d = gnt1 ? req1_op : req0_op;
        end
      end
      ST_EXEC: begin
      end
      ST_CAPT: begin
        data_d  = alu_result;
        valid_d = 1'b1;
      end
      ST_RESP: begin
        if (resp_ready) valid_d = 1'b0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cont_q  <= 3'b000;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      prio_q  <= prio_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cont_q  <= cont_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_cont   = cont_q;
  assign resp_valid = valid_q;
  assign resp_data  = data_q;
  assign resp_id    = id_q;

  a_one_grant : assert property (@(posedge clk) disable iff (reset)
    !(req0_ready && req1_ready));

  a_resp_hold : assert property (@(posedge clk) disable iff (reset)
    (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_data) && $stable(resp_id)));

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; a behavioural alu_reg closes the loop on alu_result.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_ready;
  logic [7:0] req0_a, req0_b;
  logic [2:0] req0_op;
  logic       req1_valid, req1_ready;
  logic [7:0] req1_a, req1_b;
  logic [2:0] req1_op;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_cont;
  logic       resp_valid, resp_ready, resp_id;
  logic [7:0] resp_data;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cont(alu_cont), .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id)
  );

  always #5 clk = ~clk;

  // alu_reg: b optionally inverted with carry-in, low bits pick AND/OR/ADD/SLT.
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] c);
    logic [7:0] bb, s;
    bb = c[2] ? ~b : b;
    s  = a + bb + {7'b0, c[2]};
    case (c[1:0])
      2'b00:   return a & bb;
      2'b01:   return a | bb;
      2'b10:   return s;
      default: return {7'b0, s[7]};
    endcase
  endfunction

  always_ff @(posedge clk) alu_result <= alu_f(alu_a, alu_b, alu_cont);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic id, input logic [7:0] a,
                        input logic [7:0] b, input logic [2:0] op, input logic [7:0] exp);
    @(negedge clk);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    #1;
    check_val({tag, "_rdy"}, 32'(id ? req1_ready : req0_ready), 1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check_val({tag, "_alu_a"}, 32'(alu_a), 32'(a));
    check_val({tag, "_alu_cont"}, 32'(alu_cont), 32'(op));
    @(negedge clk); #1;
    check_val({tag, "_early_vld"}, 32'(resp_valid), 0);
    @(negedge clk); #1;
    check_val({tag, "_vld"}, 32'(resp_valid), 1);
    check_val({tag, "_data"}, 32'(resp_data), 32'(exp));
    check_val({tag, "_id"}, 32'(resp_id), 32'(id));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; resp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    repeat (3) @(negedge clk);
    req0_valid = 1'b1;
    #1;
    check_val("rst_resp_valid", 32'(resp_valid), 0);
    check_val("rst_resp_data", 32'(resp_data), 0);
    check_val("rst_resp_id", 32'(resp_id), 0);
    check_val("rst_alu_a", 32'(alu_a), 0);
    check_val("rst_alu_b", 32'(alu_b), 0);
    check_val("rst_alu_cont", 32'(alu_cont), 0);
    check_val("rst_req0_ready", 32'(req0_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    req0_valid = 1'b0;

    // Basic add from requester 0, then the remaining opcodes from requester 1.
    run_op("t1_add", 1'b0, 8'h0C, 8'h0A, 3'b010, 8'h16);
    run_op("t2_sub", 1'b1, 8'h05, 8'h07, 3'b110, 8'hFE);
    run_op("t2_slt", 1'b1, 8'h05, 8'h07, 3'b111, 8'h01);
    run_op("t2_and", 1'b1, 8'hF0, 8'h3C, 3'b000, 8'h30);
    run_op("t2_or",  1'b1, 8'hF0, 8'h3C, 3'b001, 8'hFC);

    // Both requesters held valid: grants must alternate starting with 0.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02; req0_op = 3'b010;
    req1_valid = 1'b1; req1_a = 8'h0A; req1_b = 8'h03; req1_op = 3'b110;
    #1;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 10) begin
        @(negedge clk); #1; n++;
      end
      check_val("t3_grant_seen", 32'(n < 10), 1);
      check_val("t3_grant1", 32'(req1_ready), 32'(g % 2));
      check_val("t3_grant0", 32'(req0_ready), 32'(1 - (g % 2)));
      n = 0;
      @(negedge clk); #1;
      while (!resp_valid && n < 10) begin
        @(negedge clk); #1; n++;
      end
      check_val("t3_resp_seen", 32'(n < 10), 1);
      check_val("t3_resp_id", 32'(resp_id), 32'(g % 2));
      check_val("t3_resp_data", 32'(resp_data), (g % 2) ? 32'h07 : 32'h03);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Back-pressure in RESP: response frozen, no accepts, then release.
    @(negedge clk);
    resp_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h05; req1_b = 8'h07; req1_op = 3'b010;
    #1;
    check_val("t4_rdy1", 32'(req1_ready), 1);
    @(negedge clk);
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h03; req0_b = 8'h04; req0_op = 3'b010;
    #1;
    check_val("t4_exec_rdy0", 32'(req0_ready), 0);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      check_val("t4_hold_vld", 32'(resp_valid), 1);
      check_val("t4_hold_data", 32'(resp_data), 32'h0C);
      check_val("t4_hold_id", 32'(resp_id), 1);
      check_val("t4_hold_rdy0", 32'(req0_ready), 0);
      check_val("t4_hold_rdy1", 32'(req1_ready), 0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    #1;
    check_val("t4_last_vld", 32'(resp_valid), 1);
    @(negedge clk); #1;
    check_val("t4_idle_vld", 32'(resp_valid), 0);
    check_val("t4_next_rdy0", 32'(req0_ready), 1);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    check_val("t4_next_data", 32'(resp_data), 32'h07);
    check_val("t4_next_id", 32'(resp_id), 0);

    // Reset during EXEC drops the op and restores req0 priority.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h01; req0_op = 3'b010;
    #1;
    check_val("t5_rdy0", 32'(req0_ready), 1);
    @(negedge clk);
    req0_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("t5_rst_vld", 32'(resp_valid), 0);
    check_val("t5_rst_alu_a", 32'(alu_a), 0);
    check_val("t5_rst_data", 32'(resp_data), 0);
    repeat (3) begin
      @(negedge clk); #1;
      check_val("t5_no_resp", 32'(resp_valid), 0);
    end
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 8'h02; req0_b = 8'h03; req0_op = 3'b010;
    req1_valid = 1'b1; req1_a = 8'h09; req1_b = 8'h09; req1_op = 3'b110;
    #1;
    check_val("t5_prio_rdy0", 32'(req0_ready), 1);
    check_val("t5_prio_rdy1", 32'(req1_ready), 0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    check_val("t5_resp_data", 32'(resp_data), 32'h05);
    check_val("t5_resp_id", 32'(resp_id), 0);

    // A request pulsed while busy is withdrawn and never served.
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 8'hF0; req1_b = 8'h0F; req1_op = 3'b001;
    #1;
    check_val("t6_rdy1", 32'(req1_ready), 1);
    @(negedge clk);
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    #1;
    check_val("t6_exec_rdy0", 32'(req0_ready), 0);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    check_val("t6_capt_rdy0", 32'(req0_ready), 0);
    @(negedge clk); #1;
    check_val("t6_resp_data", 32'(resp_data), 32'hFF);
    check_val("t6_resp_id", 32'(resp_id), 1);
    repeat (6) begin
      @(negedge clk); #1;
      check_val("t6_no_grant", 32'(req0_ready), 0);
      check_val("t6_no_resp", 32'(resp_valid), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
